// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  conv_pkg
//  Shared types and widths for the conv2 / pooling schedulers.
//  Revision: 1.0
// ============================================================================
package conv_pkg;

    localparam int unsigned CONV_K      = 5;
    localparam int unsigned KK          = CONV_K * CONV_K;
    localparam int unsigned CONV_ADDR_W = 8;
    localparam int unsigned COORD_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_EMIT    = 3'd3,
        S_ADVANCE = 3'd4
    } state_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv2_sched_if.sv
`default_nettype none
// ============================================================================
//  conv2_sched_if
//  Frame control, feature-buffer read, conv-layer and pooling handshake bus.
//  Revision: 1.0
// ============================================================================
interface conv2_sched_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = CONV_ADDR_W
) ();

    logic               frame_start;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               tap_valid;
    logic               conv_start;
    logic               conv_ready;
    logic               pool_ready;
    logic               out_valid;
    logic               out_ack;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic               busy;
    logic               frame_done;
    logic               err;

    modport master (
        input  frame_start, conv_ready, out_ack,
        output rd_en, rd_addr, tap_valid, conv_start, pool_ready,
               out_valid, out_row, out_col, busy, frame_done, err
    );

    modport slave (
        output frame_start, conv_ready, out_ack,
        input  rd_en, rd_addr, tap_valid, conv_start, pool_ready,
               out_valid, out_row, out_col, busy, frame_done, err
    );

endinterface
`default_nettype wire

// File: rtl/conv2_win_cnt.sv
`default_nettype none
// ============================================================================
//  conv2_win_cnt
//  Nested kh/kw tap and row/col pixel counters plus window address generator.
//  Revision: 1.0
// ============================================================================
module conv2_win_cnt
    import conv_pkg::*;
#(
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 12,
    parameter int K      = 5,
    parameter int ADDR_W = 8
) (
    input  wire logic               clk,
    input  wire logic               n_reset,
    input  wire logic               clr_i,
    input  wire logic               tap_step_i,
    input  wire logic               pix_step_i,
    output logic                    tap_last_o,
    output logic                    pix_last_o,
    output logic [COORD_W-1:0]      row_o,
    output logic [COORD_W-1:0]      col_o,
    output logic [ADDR_W-1:0]       addr_o
);

    localparam int KC_W = cnt_w(K);
    localparam int AW1  = ADDR_W + 1;

    localparam logic [KC_W-1:0]    KMAX   = KC_W'(K - 1);
    localparam logic [COORD_W-1:0] OW_MAX = COORD_W'(IMG_W - K);
    localparam logic [COORD_W-1:0] OH_MAX = COORD_W'(IMG_H - K);

    logic [KC_W-1:0]    kh_q, kw_q;
    logic [COORD_W-1:0] row_q, col_q;
    logic [AW1-1:0]     w_r, w_c, w_addr;

    always_ff @(posedge clk) begin
        if (!n_reset || clr_i) begin
            kh_q  <= '0;
            kw_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            if (tap_step_i) begin
                if (kw_q == KMAX) begin
                    kw_q <= '0;
                    kh_q <= (kh_q == KMAX) ? '0 : kh_q + KC_W'(1);
                end else begin
                    kw_q <= kw_q + KC_W'(1);
                end
            end
            // Row also wraps after the last pixel so IDLE presents address 0.
            if (pix_step_i) begin
                if (col_q == OW_MAX) begin
                    col_q <= '0;
                    row_q <= (row_q == OH_MAX) ? '0 : row_q + COORD_W'(1);
                end else begin
                    col_q <= col_q + COORD_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_r    = AW1'(row_q) + AW1'(kh_q);
        w_c    = AW1'(col_q) + AW1'(kw_q);
        w_addr = w_r * AW1'(IMG_W) + w_c;
    end

    assign addr_o     = ADDR_W'(w_addr);
    assign tap_last_o = (kh_q == KMAX) && (kw_q == KMAX);
    assign pix_last_o = (row_q == OH_MAX) && (col_q == OW_MAX);
    assign row_o      = row_q;
    assign col_o      = col_q;

endmodule
`default_nettype wire

// File: rtl/conv2_sched.sv
`default_nettype none
// ============================================================================
//  conv2_sched
//  Per-pixel sequencer: window fetch, conv wait, pooling handoff, frame done.
//  Revision: 1.0
// ============================================================================
module conv2_sched
    import conv_pkg::*;
#(
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 12,
    parameter int K      = 5,
    parameter int ADDR_W = 8
) (
    input  wire logic    clk,
    input  wire logic    n_reset,
    conv2_sched_if.master bus
);

    state_e state_q, state_d;

    logic rd_en_q, conv_start_q, tap_valid_q, out_valid_q;
    logic busy_q, frame_done_q, err_q;

    logic w_clr, w_tap_step, w_pix_step, w_err_set;
    logic w_tap_last, w_pix_last;

    conv2_win_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_win_cnt (
        .clk        (clk),
        .n_reset    (n_reset),
        .clr_i      (w_clr),
        .tap_step_i (w_tap_step),
        .pix_step_i (w_pix_step),
        .tap_last_o (w_tap_last),
        .pix_last_o (w_pix_last),
        .row_o      (bus.out_row),
        .col_o      (bus.out_col),
        .addr_o     (bus.rd_addr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.frame_start) state_d = S_FETCH;
            S_FETCH:   if (w_tap_last)      state_d = S_WAIT;
            S_WAIT:    if (bus.conv_ready)  state_d = S_EMIT;
            S_EMIT:    if (bus.out_ack)     state_d = S_ADVANCE;
            S_ADVANCE: state_d = w_pix_last ? S_IDLE : S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    assign w_clr      = (state_q == S_IDLE) && bus.frame_start;
    assign w_tap_step = (state_q == S_FETCH);
    assign w_pix_step = (state_q == S_ADVANCE);

    // Protocol violations are flagged but never alter sequencing.
    assign w_err_set  = ((state_q == S_FETCH) && bus.conv_ready)
                      || (bus.out_ack && !out_valid_q)
                      || ((state_q != S_IDLE) && bus.frame_start);

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= S_IDLE;
            rd_en_q      <= 1'b0;
            conv_start_q <= 1'b0;
            tap_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= (state_d == S_FETCH);
            conv_start_q <= (state_d == S_FETCH) && (state_q != S_FETCH);
            tap_valid_q  <= rd_en_q;
            out_valid_q  <= (state_d == S_EMIT);
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= (state_d == S_ADVANCE) && w_pix_last;
            err_q        <= w_clr ? w_err_set : (err_q || w_err_set);
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.conv_start = conv_start_q;
    assign bus.tap_valid  = tap_valid_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.pool_ready = out_valid_q && bus.out_ack;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule
`default_nettype wire
